mips_cpu_muldiv: RTL and testbench

//  Parametrised multi-cycle HI/LO multiply/divide unit for the multi-cycle MIPS core.

---
 rtl/mips_cpu_pkg.sv | 39 +++
 rtl/mips_cpu_div_step.sv | 34 +++
 rtl/mips_cpu_muldiv.sv | 222 ++++++++++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared op/state enums and funct codes for the MIPS core
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } muldiv_state_t;

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    // Decoder helper: SPECIAL-opcode funct field to muldiv op (unknown codes map to MULT;
    // the decoder only calls this for the six funct values above).
    function automatic muldiv_op_t funct_to_op(input logic [5:0] funct);
        case (funct)
            F_MULTU: return MULTU;
            F_DIV:   return DIV;
            F_DIVU:  return DIVU;
            F_MTHI:  return MTHI;
            F_MTLO:  return MTLO;
            default: return MULT;
        endcase
    endfunction

endpackage

// File: rtl/mips_cpu_div_step.sv
// rtl/mips_cpu_div_step.sv - combinational multi-bit restoring divide step
module mips_cpu_div_step #(
    parameter int WIDTH = 32,
    parameter int BITS  = 1
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;

    // Retire BITS quotient bits: shift the next dividend bit into the partial
    // remainder, subtract the divisor when it fits. One spare bit holds the shifted
    // remainder, which can exceed WIDTH bits before the subtract.
    always_comb begin
        r = {1'b0, rem_i};
        q = quo_i;
        for (int k = 0; k < BITS; k++) begin
            r = {r[WIDTH-1:0], q[WIDTH-1]};
            q = {q[WIDTH-2:0], 1'b0};
            if (r >= {1'b0, divisor_i}) begin
                r    = r - {1'b0, divisor_i};
                q[0] = 1'b1;
            end
        end
        rem_o = r[WIDTH-1:0];
        quo_o = q;
    end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// rtl/mips_cpu_muldiv.sv - iterative HI/LO mul/div unit; MIPS_MULDIV_FAST_MUL_EN selects single-cycle multiply
module mips_cpu_muldiv
    import mips_cpu_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0]        CNT_INIT = CW'(N - 1);
    localparam logic [CW-1:0]        ONE_C    = CW'(1);
    localparam logic [WIDTH-1:0]     ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0]   ONE_P    = (2*WIDTH)'(1);

    muldiv_state_t state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;   // product / quotient is negative
    logic                 neg_rem_q, neg_rem_d;   // remainder follows dividend sign
    logic                 divz_q, divz_d;
    logic [WIDTH-1:0]     opa_q, opa_d;           // |multiplicand|
    logic [WIDTH-1:0]     opb_q, opb_d;           // |divisor| / |multiplier|
    logic [WIDTH-1:0]     sh_q, sh_d;             // multiplier or dividend->quotient
    logic [2*WIDTH-1:0]   acc_q, acc_d;           // product, or remainder in low half
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    muldiv_op_t           op_e;
    logic                 op_signed, op_div, op_arith, accept, launch;
    logic [2*WIDTH-1:0]   mul_p;
    logic [WIDTH-1:0]     mul_m;
    logic [WIDTH-1:0]     div_rem, div_quo;
    logic [2*WIDTH-1:0]   prod_mag, prod_s;
    logic [WIDTH-1:0]     quo_s, rem_s;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + ONE_W) : v;
    endfunction

    assign op_e      = muldiv_op_t'(op);
    assign op_signed = (op_e == MULT) || (op_e == DIV);
    assign op_div    = (op_e == DIV) || (op_e == DIVU);
    assign op_arith  = (op_e == MULT) || (op_e == MULTU) || op_div;
    assign accept    = (state_q == IDLE) && start && !flush;
    assign launch    = accept && op_arith;

    mips_cpu_div_step #(
        .WIDTH (WIDTH),
        .BITS  (BITS_PER_CYCLE)
    ) u_div_step (
        .rem_i     (acc_q[WIDTH-1:0]),
        .quo_i     (sh_q),
        .divisor_i (opb_q),
        .rem_o     (div_rem),
        .quo_o     (div_quo)
    );

    // Multiply step: MSB-first shift-add of BITS_PER_CYCLE multiplier bits.
    always_comb begin
        mul_p = acc_q;
        mul_m = sh_q;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            mul_p = mul_p << 1;
            if (mul_m[WIDTH-1]) begin
                mul_p = mul_p + {{WIDTH{1'b0}}, opa_q};
            end
            mul_m = mul_m << 1;
        end
    end

`ifdef MIPS_MULDIV_FAST_MUL_EN
    assign prod_mag = {{WIDTH{1'b0}}, opa_q} * {{WIDTH{1'b0}}, opb_q};
`else
    assign prod_mag = acc_q;
`endif

    // Sign correction applied on the FIX edge.
    always_comb begin
        prod_s = neg_res_q ? (~prod_mag + ONE_P) : prod_mag;
        quo_s  = neg_res_q ? (~sh_q + ONE_W) : sh_q;
        rem_s  = neg_rem_q ? (~acc_q[WIDTH-1:0] + ONE_W) : acc_q[WIDTH-1:0];
    end

    // FSM next state: flush always returns a busy unit to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (launch) begin
`ifdef MIPS_MULDIV_FAST_MUL_EN
                    state_d = op_div ? RUN : FIX;
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next state: operand latch, iteration, and HI/LO writeback.
    always_comb begin
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        divz_d    = divz_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        sh_d      = sh_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    opa_d     = mag(a, op_signed);
                    opb_d     = mag(b, op_signed);
                    sh_d      = op_div ? mag(a, op_signed) : mag(b, op_signed);
                    acc_d     = '0;
                    cnt_d     = CNT_INIT;
                    is_div_d  = op_div;
                    neg_res_d = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = op_signed && a[WIDTH-1];
                    divz_d    = op_div && (b == '0);
                end else if (accept && op_e == MTHI) begin
                    hi_d = a;
                end else if (accept && op_e == MTLO) begin
                    lo_d = a;
                end
            end
            RUN: begin
                if (!flush) begin
                    cnt_d = cnt_q - ONE_C;
                    if (is_div_q) begin
                        acc_d = {{WIDTH{1'b0}}, div_rem};
                        sh_d  = div_quo;
                    end else begin
                        acc_d = mul_p;
                        sh_d  = mul_m;
                    end
                end
            end
            FIX: begin
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        lo_d = divz_q ? '1 : quo_s;
                        hi_d = rem_s;
                    end else begin
                        hi_d = prod_s[2*WIDTH-1:WIDTH];
                        lo_d = prod_s[WIDTH-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
            sh_q      <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            divz_q    <= divz_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            sh_q      <= sh_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// tb/tb_mips_cpu_muldiv.sv - scoreboard bench for the HI/LO multiply/divide unit
module tb_mips_cpu_muldiv;
    import mips_cpu_pkg::*;

    localparam int W       = 32;
    localparam int BPC     = 1;
    localparam int N       = W / BPC;
    localparam int LAT_DIV = N + 1;
`ifdef MIPS_MULDIV_FAST_MUL_EN
    localparam int LAT_MUL = 1;
`else
    localparam int LAT_MUL = N + 1;
`endif

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    res_t         sb[$];
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    int           errors = 0;
    int           checks = 0;

    mips_cpu_muldiv #(.WIDTH(W), .BITS_PER_CYCLE(BPC)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input muldiv_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
        res_t r;
        logic signed [2*W-1:0] sp;
        logic [W-1:0] mn;
        mn = {1'b1, {(W-1){1'b0}}};
        r  = '0;
        case (o)
            MULT: begin
                sp = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
                r  = sp;
            end
            MULTU: r = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            DIV: begin
                if (y == '0) begin
                    r.hi = x; r.lo = '1;
                end else if (x == mn && y == '1) begin
                    r.hi = '0; r.lo = mn;
                end else begin
                    r.lo = $signed(x) / $signed(y);
                    r.hi = $signed(x) % $signed(y);
                end
            end
            DIVU: begin
                if (y == '0) begin
                    r.hi = x; r.lo = '1;
                end else begin
                    r.lo = x / y;
                    r.hi = x % y;
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic do_op(input muldiv_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
        res_t e;
        int lat, bc, lat_exp;
        sb.push_back(model(o, x, y));
        lat_exp = (o == DIV || o == DIVU) ? LAT_DIV : LAT_MUL;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bc = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) bc++;
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== lat_exp) begin
            errors++; $display("FAIL latency op=%0d: got %0d edges, expected %0d", o, lat, lat_exp);
        end
        checks++;
        if (bc !== lat_exp) begin
            errors++; $display("FAIL busy_cycles op=%0d: got %0d, expected %0d", o, bc, lat_exp);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL busy_with_done op=%0d: busy=%b expected 0", o, busy);
        end
        e = sb.pop_front();
        checks++;
        if (hi !== e.hi || lo !== e.lo) begin
            errors++;
            $display("FAIL result op=%0d a=%h b=%h: hi=%h lo=%h expected hi=%h lo=%h", o, x, y, hi, lo, e.hi, e.lo);
        end
        exp_hi = e.hi; exp_lo = e.lo;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
            errors++;
            $display("FAIL done_pulse op=%0d: done=%b hi=%h lo=%h expected done=0 hi=%h lo=%h", o, done, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic do_mt(input muldiv_op_t o, input logic [W-1:0] x);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = '0;
        @(posedge clk); #1;
        start = 1'b0;
        if (o == MTHI) exp_hi = x; else exp_lo = x;
        checks++;
        if (hi !== exp_hi || lo !== exp_lo || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mtxx op=%0d: hi=%h lo=%h busy=%b done=%b expected hi=%h lo=%h busy=0 done=0", o, hi, lo, busy, done, exp_hi, exp_lo);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mtxx_after op=%0d: busy=%b done=%b expected 0 0", o, busy, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        exp_hi = '0; exp_lo = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            errors++; $display("FAIL reset: busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
        end
        reset = 1'b1;
    endtask

    task automatic test_mul();
        do_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        do_op(MULT,  32'hFFFFFFFD, 32'd5);
        do_op(MULT,  32'h80000000, 32'h80000000);
        do_op(MULTU, 32'd0, 32'h12345678);
    endtask

    task automatic test_div();
        do_op(DIV,  32'hFFFFFFF9, 32'd2);
        do_op(DIVU, 32'd7, 32'd2);
        do_op(DIV,  32'h00001234, 32'd0);
        do_op(DIV,  32'h80000000, 32'hFFFFFFFF);
        do_op(DIVU, 32'hFFFFFFFF, 32'd0);
        do_op(DIV,  32'd100, 32'hFFFFFFF9);
    endtask

    task automatic test_mtxx_flush();
        int seen;
        do_mt(MTHI, 32'hCAFEF00D);
        do_mt(MTLO, 32'h12345678);
        @(posedge clk); #1;
        start = 1'b1; op = DIVU; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
            errors++;
            $display("FAIL flush_run: busy=%b done=%b hi=%h lo=%h expected busy=0 done=0 hi=%h lo=%h", busy, done, hi, lo, exp_hi, exp_lo);
        end
        seen = 0;
        start = 1'b1; op = MULTU; a = 32'd3; b = 32'd4; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL flush_start: busy=%b expected 0", busy);
        end
        repeat (40) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen !== 0 || hi !== exp_hi || lo !== exp_lo) begin
            errors++;
            $display("FAIL flush_quiet: activity=%0d hi=%h lo=%h expected 0 hi=%h lo=%h", seen, hi, lo, exp_hi, exp_lo);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        do_op(DIVU, 32'd1000, 32'd7);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        start = 1'b1; op = DIVU; a = 32'h00ABCDEF; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            errors++; $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
        end
        exp_hi = '0; exp_lo = '0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_busy_ignore();
        res_t e;
        int lat;
        sb.push_back(model(MULTU, 32'h0001_0003, 32'h0000_0007));
        @(posedge clk); #1;
        start = 1'b1; op = MULTU; a = 32'h0001_0003; b = 32'h0000_0007;
        @(posedge clk); #1;
        op = DIVU; a = 32'd5; b = 32'd0;
        if (LAT_MUL > 3) begin
            repeat (3) begin @(posedge clk); #1; end
        end
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || hi !== e.hi || lo !== e.lo) begin
            errors++;
            $display("FAIL busy_ignore: done=%b hi=%h lo=%h expected done=1 hi=%h lo=%h", done, hi, lo, e.hi, e.lo);
        end
        exp_hi = e.hi; exp_lo = e.lo;
    endtask

    task automatic test_random();
        muldiv_op_t o;
        logic [W-1:0] x, y;
        for (int i = 0; i < 8; i++) begin
            o = muldiv_op_t'($urandom_range(0, 3));
            x = $urandom;
            y = (i % 3 == 0) ? W'($urandom_range(0, 9)) : $urandom;
            if (i % 2 == 0) y = ~y + 1'b1;
            do_op(o, x, y);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_mtxx_flush();
        test_reset_mid();
        test_busy_ignore();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
